dct_coef_sequencer: RTL and testbench

//  Sequences compute_cos_terms over every (k1,k2) pair of an N x N DCT basis.

---
 rtl/dct_coef_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_dct_coef_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_coef_sequencer.sv
// dct_coef_sequencer: walks every (k1,k2) pair of an N x N DCT basis, hands each
// pair to one compute_cos_terms instance and writes its result into the
// coefficient RAM at address {k1,k2}.
//
// Optional feature macro: DCT_SEQ_TIMEOUT_EN
//   defined   : a pair that takes TIMEOUT_CYC WAIT cycles without cos_finish is
//               written as 0, err_timeout goes sticky high, and the build goes on.
//   undefined : WAIT holds until cos_finish or abort; err_timeout is tied low.
//
// Handshake with compute_cos_terms: cos_start is a level, high in ISSUE and WAIT
// only. cos_finish is sampled only in WAIT; k1/k2 are held stable for as long as
// cos_start is high, and cos_start drops for the WRITE cycle between pairs.
// All outputs come straight from flops; nothing is combinational from an input.
module dct_coef_sequencer #(
  parameter  int N           = 8,
  parameter  int DATA_W      = 32,
  parameter  int TIMEOUT_CYC = 512,
  localparam int KW          = $clog2(N),
  localparam int AW          = $clog2(N * N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic [KW-1:0]     k1,
  output logic [KW-1:0]     k2,
  output logic              cos_start,
  input  logic              cos_finish,
  input  logic [DATA_W-1:0] cos_c,
  output logic              wr_en,
  output logic [AW-1:0]     wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [2:0]        dbg_state
);

  // Elaboration-time parameter sanity.
  if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_n
    $error("dct_coef_sequencer: N must be a power of 2 and >= 2");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_tmo
    $error("dct_coef_sequencer: TIMEOUT_CYC must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [KW-1:0] K_MAX = KW'(N - 1);

  state_t              state_q, state_d;
  logic [KW-1:0]       k1_q, k1_d;
  logic [KW-1:0]       k2_q, k2_d;
  logic [AW-1:0]       wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                cos_start_q, cos_start_d;
  logic                wr_en_q, wr_en_d;
  logic                err_q, err_d;

`ifdef DCT_SEQ_TIMEOUT_EN
  localparam int            TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0]            tmo_cnt_q, tmo_cnt_d;
`endif

  // Next-state, index, capture and registered-output decode.
  always_comb begin
    state_d   = state_q;
    k1_d      = k1_q;
    k2_d      = k2_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = err_q;
`ifdef DCT_SEQ_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (go && !abort) begin
          state_d = S_ISSUE;
          k1_d    = '0;
          k2_d    = '0;
          err_d   = 1'b0;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef DCT_SEQ_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      S_WAIT: begin
        if (cos_finish) begin
          wr_data_d = cos_c;
          wr_addr_d = {k1_q, k2_q};
          state_d   = S_WRITE;
        end
`ifdef DCT_SEQ_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          // Give up on this pair: write 0 and flag it, then keep building.
          wr_data_d = '0;
          wr_addr_d = {k1_q, k2_q};
          err_d     = 1'b1;
          state_d   = S_WRITE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
`endif
      end
      S_WRITE: begin
        if (k1_q == K_MAX && k2_q == K_MAX) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ISSUE;
          k2_d    = k2_q + KW'(1);
          if (k2_q == K_MAX) begin
            k1_d = k1_q + KW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides whatever the state wanted, including a same-cycle finish.
    if (abort && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      k1_d      = k1_q;
      k2_d      = k2_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      err_d     = err_q;
    end

    busy_d      = (state_d != S_IDLE);
    cos_start_d = (state_d == S_ISSUE) || (state_d == S_WAIT);
    wr_en_d     = (state_d == S_WRITE);
    done_d      = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      k1_q        <= '0;
      k2_q        <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cos_start_q <= 1'b0;
      wr_en_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      k1_q        <= k1_d;
      k2_q        <= k2_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cos_start_q <= cos_start_d;
      wr_en_q     <= wr_en_d;
      err_q       <= err_d;
    end
  end

`ifdef DCT_SEQ_TIMEOUT_EN
  // WAIT-cycle counter for the per-pair timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign busy      = busy_q;
  assign done      = done_q;
  assign k1        = k1_q;
  assign k2        = k2_q;
  assign cos_start = cos_start_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dct_coef_sequencer.sv
// Bench for dct_coef_sequencer (N=8). A compute_cos_terms stand-in answers each
// pair after a per-address latency; a schedule model predicts, from those
// latencies alone, the cycle/address/data of every write, the done cycle and
// the busy window. One checker process compares every cycle.
module tb_dct_coef_sequencer;
  localparam int N   = 8;
  localparam int NN  = N * N;
  localparam int KW  = 3;
  localparam int AW  = 6;
  localparam int DW  = 32;
  localparam int TMO = 512;
  localparam int INF = 1 << 30;

  logic          clk = 1'b0;
  logic          reset, go, abort;
  logic          busy, done, err_timeout, cos_start, wr_en;
  logic [KW-1:0] k1, k2;
  logic          cos_finish = 1'b0;
  logic [DW-1:0] cos_c = '0;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [2:0]    dbg_state;

  dct_coef_sequencer #(.N(N), .DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .go(go), .abort(abort),
    .busy(busy), .done(done), .err_timeout(err_timeout),
    .k1(k1), .k2(k2), .cos_start(cos_start),
    .cos_finish(cos_finish), .cos_c(cos_c),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dbg_state(dbg_state)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state.
  int            checks = 0;
  int            errors = 0;
  int            exp_cyc_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_q[$];
  int            win_lo = 0, win_hi = 0, done_cyc = -1, err_set = -1;
  int            wr_cnt = 0, done_seen = -1;
  logic [DW-1:0] pin7 = '1;
  bit            chk_en = 1'b0;

  // Stand-in for compute_cos_terms: latency 0 means never answers.
  int            lat_tbl[NN];
  logic [DW-1:0] data_tbl[NN];
  int            st_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Responder: finish on the F-th WAIT cycle (cos_start high for F+1 cycles);
  // random finish noise whenever cos_start is low.
  always @(negedge clk) begin
    int a;
    if (cos_start === 1'b1) st_cnt = st_cnt + 1;
    else                    st_cnt = 0;
    a = int'({k1, k2});
    if (cos_start === 1'b1)
      cos_finish = (lat_tbl[a] != 0) && (st_cnt == lat_tbl[a] + 1);
    else
      cos_finish = ($urandom_range(0, 3) == 0);
    cos_c = (cos_start === 1'b1 && cos_finish) ? data_tbl[a] : $urandom();
  end

  // Schedule model: pair i is written at g + sum_{j<=i}(2+F_j); done one cycle later.
  task automatic plan_build(input int g);
    int t;
    t = g;
    exp_cyc_q.delete(); exp_addr_q.delete(); exp_q.delete();
    err_set = -1; done_cyc = -1; win_lo = g; win_hi = INF;
    wr_cnt = 0; done_seen = -1; pin7 = '1;
    for (int i = 0; i < NN; i++) begin
      int f;
      logic [DW-1:0] d;
      if (lat_tbl[i] == 0) begin
`ifdef DCT_SEQ_TIMEOUT_EN
        f = TMO; d = '0;
`else
        return;
`endif
      end else begin
        f = lat_tbl[i]; d = data_tbl[i];
      end
      t = t + 2 + f;
      if (lat_tbl[i] == 0 && err_set < 0) err_set = t;
      exp_cyc_q.push_back(t);
      exp_addr_q.push_back(AW'(i));
      exp_q.push_back(d);
    end
    done_cyc = t + 1;
    win_hi   = t + 1;
  endtask

  // Abandon the predicted build from the next cycle on (abort or reset).
  task automatic cancel_model(input bit clear_err);
    exp_cyc_q.delete(); exp_addr_q.delete(); exp_q.delete();
    done_cyc = -1;
    win_hi   = cyc;
    if (clear_err) err_set = -1;
  endtask

  // Per-cycle compare against the model.
  logic          prev_start = 1'b0;
  logic [KW-1:0] prev_k1 = '0, prev_k2 = '0;
  always @(negedge clk) begin
    if (chk_en) begin
      bit e_wr, e_busy, e_done, e_start, e_err;
      e_wr    = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == cyc);
      e_busy  = (cyc > win_lo) && (cyc <= win_hi);
      e_done  = (cyc == done_cyc);
      e_start = e_busy && !e_wr && !e_done;
      e_err   = (err_set >= 0) && (cyc >= err_set);
      chk("busy", 64'(busy), 64'(e_busy));
      chk("done", 64'(done), 64'(e_done));
      chk("cos_start", 64'(cos_start), 64'(e_start));
      chk("wr_en", 64'(wr_en), 64'(e_wr));
      chk("err_timeout", 64'(err_timeout), 64'(e_err));
      if (e_wr) begin
        if (wr_en) begin
          chk("wr_addr", 64'(wr_addr), 64'(exp_addr_q[0]));
          chk("wr_data", 64'(wr_data), 64'(exp_q[0]));
        end
        void'(exp_cyc_q.pop_front()); void'(exp_addr_q.pop_front()); void'(exp_q.pop_front());
      end
      if (wr_en) begin
        wr_cnt++;
        if (wr_addr == AW'(7)) pin7 = wr_data;
      end
      if (done) done_seen = cyc;
      if (prev_start && cos_start)
        chk("k_stable", 64'({k1, k2}), 64'({prev_k1, prev_k2}));
      prev_start = cos_start; prev_k1 = k1; prev_k2 = k2;
    end
  end

  // Driver tasks: inputs change 1 time unit after the falling edge.
  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic start_build();
    go = 1'b1;
    plan_build(cyc);
    step();
    go = 1'b0;
  endtask

  task automatic wait_pair(input int addr, input bit need_fin, output bit ok);
    int n = 0;
    while (!(cos_start && int'({k1, k2}) == addr && (!need_fin || cos_finish)) && n < 3000) begin
      step(); n++;
    end
    ok = (n < 3000);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (cyc <= win_hi && n < 5000) begin step(); n++; end
    checks++;
    if (n >= 5000) begin
      errors++;
      $display("FAIL %s wait budget expired cyc=%0d got=busy expected=idle", name, cyc);
    end
    step();
  endtask

  task automatic fill_tables(input int lat, input bit rnd);
    for (int i = 0; i < NN; i++) begin
      lat_tbl[i]  = rnd ? int'($urandom_range(1, 12)) : lat;
      data_tbl[i] = rnd ? $urandom() : DW'(i);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_err"}, 64'(err_timeout), 0);
    chk({tag, "_k"}, 64'({k1, k2}), 0);
    chk({tag, "_start"}, 64'(cos_start), 0);
    chk({tag, "_wr_en"}, 64'(wr_en), 0);
    chk({tag, "_wr_addr"}, 64'(wr_addr), 0);
    chk({tag, "_wr_data"}, 64'(wr_data), 0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    bit ok;
    int g;
    go = 1'b0; abort = 1'b0; reset = 1'b1;
    fill_tables(20, 1'b0);
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    #1 reset = 1'b0;
    chk_en = 1'b1;
    step();

    // Full build, F=20, data==addr.
    g = cyc;
    start_build();
    wait_idle("build1");
    chk("pin_writes", 64'(wr_cnt), 64);
    chk("pin_done_cycle", 64'(done_seen - g), 1409);
    chk("pin_last_addr", 64'(wr_addr), 63);

    // go + abort together in IDLE: must stay idle.
    go = 1'b1; abort = 1'b1;
    step();
    go = 1'b0; abort = 1'b0;
    chk("go_abort_idle", 64'(busy), 0);
    step();

    // go pulses while busy at pairs 5 and 63 are ignored.
    g = cyc;
    start_build();
    wait_pair(5, 1'b0, ok);  chk("reach_pair5", 64'(ok), 1);
    go = 1'b1; step(); go = 1'b0;
    wait_pair(63, 1'b0, ok); chk("reach_pair63", 64'(ok), 1);
    go = 1'b1; step(); go = 1'b0;
    wait_idle("build_go_busy");
    chk("pin_writes_go_busy", 64'(wr_cnt), 64);
    chk("pin_done_go_busy", 64'(done_seen - g), 1409);

    // Abort in the same cycle as cos_finish on pair 10, then restart.
    start_build();
    wait_pair(10, 1'b1, ok); chk("reach_fin10", 64'(ok), 1);
    abort = 1'b1;
    cancel_model(1'b0);
    step();
    abort = 1'b0;
    chk("abort_idle", 64'(busy), 0);
    chk("abort_writes", 64'(wr_cnt), 10);
    repeat (3) step();
    chk("abort_no_done", 64'(done_seen), 64'(-1));
    start_build();
    wait_idle("build_after_abort");
    chk("pin_writes_restart", 64'(wr_cnt), 64);

    // Reset while waiting on pair 33.
    start_build();
    wait_pair(33, 1'b0, ok); chk("reach_pair33", 64'(ok), 1);
    step();
    reset = 1'b1;
    cancel_model(1'b1);
    step();
    chk_all_zero("midreset");
    reset = 1'b0;
    repeat (3) step();
    chk("midreset_no_done", 64'(done_seen), 64'(-1));

    // Randomized latencies and data.
    for (int r = 0; r < 2; r++) begin
      fill_tables(0, 1'b1);
      start_build();
      wait_idle("build_rand");
      chk("pin_writes_rand", 64'(wr_cnt), 64);
    end

    // Pair 7 never answers.
    fill_tables(20, 1'b0);
    lat_tbl[7] = 0;
    start_build();
`ifdef DCT_SEQ_TIMEOUT_EN
    wait_idle("build_timeout");
    chk("pin_tmo_data", 64'(pin7), 0);
    chk("pin_tmo_err", 64'(err_timeout), 1);
    chk("pin_tmo_writes", 64'(wr_cnt), 64);
`else
    wait_pair(7, 1'b0, ok); chk("reach_pair7", 64'(ok), 1);
    repeat (600) step();
    chk("hang_busy", 64'(busy), 1);
    chk("hang_start", 64'(cos_start), 1);
    chk("hang_k", 64'({k1, k2}), 7);
    chk("hang_err", 64'(err_timeout), 0);
    chk("hang_writes", 64'(wr_cnt), 7);
    abort = 1'b1;
    cancel_model(1'b0);
    step();
    abort = 1'b0;
    step();
`endif

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
